// File: rtl/interval_meter.sv
// Interval meter: times a start..stop interval in clock cycles and splits it into
// whole seconds plus leftover cycles using a second/sub-second counter pair.
module interval_meter #(
  parameter int CNT_W           = 32,
  parameter int TIMEOUT_SECONDS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] clock_frequency,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] elapsed_cycles,
  output logic [CNT_W-1:0] elapsed_seconds,
  output logic [CNT_W-1:0] elapsed_remainder,
  output logic             timed_out,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_SECONDS);

  state_t           state, state_nx;
  logic [CNT_W-1:0] freq_q, cyc, sub, sec;
  logic [CNT_W-1:0] cyc_nx, sub_nx, sec_nx, sub_inc;
  logic             sub_wrap, ovf_nx, timeout_hit, finish_run;

  // Counters in RUN: cyc and sec saturate at all-ones, sub always wraps at freq_q.
  always_comb begin
    sub_inc     = sub + 1'b1;
    sub_wrap    = (sub_inc == freq_q);
    cyc_nx      = (&cyc) ? cyc : cyc + 1'b1;
    sub_nx      = sub_wrap ? '0 : sub_inc;
    sec_nx      = (sub_wrap && !(&sec)) ? sec + 1'b1 : sec;
    ovf_nx      = overflow | (&cyc) | (sub_wrap & (&sec));
    timeout_hit = (TIMEOUT_SECONDS != 0) && (sec_nx == TIMEOUT_VAL);
    finish_run  = stop || timeout_hit;
  end

  // Result handshake: result_valid rises one cycle after the run ends and holds,
  // with all result fields stable, until a clock edge sees result_valid && result_ready.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (finish_run) state_nx = DONE;
      DONE:    if (result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      freq_q    <= '0;
      cyc       <= '0;
      sub       <= '0;
      sec       <= '0;
      timed_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          // A zero frequency would never wrap sub; treat it as 1 Hz.
          freq_q    <= (clock_frequency == '0) ? CNT_W'(1) : clock_frequency;
          cyc       <= '0;
          sub       <= '0;
          sec       <= '0;
          timed_out <= 1'b0;
          overflow  <= 1'b0;
        end
        RUN: begin
          cyc      <= cyc_nx;
          sub      <= sub_nx;
          sec      <= sec_nx;
          overflow <= ovf_nx;
          if (timeout_hit && !stop) timed_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy              = (state == RUN);
  assign result_valid      = (state == DONE);
  assign elapsed_cycles    = cyc;
  assign elapsed_seconds   = sec;
  assign elapsed_remainder = sub;

endmodule

// File: tb/tb_interval_meter.sv
// Bench for interval_meter: main instance scored through an expected-result queue,
// plus a timeout instance and a narrow saturating instance checked inline.
module tb_interval_meter;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] sec;
    logic [31:0] rem;
    logic        to;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic [31:0] freq_a = '0;
  logic        start_a = 1'b0, stop_a = 1'b0, ready_a = 1'b0;
  logic        busy_a, valid_a, to_a, ov_a;
  logic [31:0] cyc_a, sec_a, rem_a;

  // timeout instance
  logic [31:0] freq_t = '0;
  logic        start_t = 1'b0, stop_t = 1'b0, ready_t = 1'b0;
  logic        busy_t, valid_t, to_t, ov_t;
  logic [31:0] cyc_t, sec_t, rem_t;

  // 4-bit saturating instance
  logic [3:0]  freq_s = '0;
  logic        start_s = 1'b0, stop_s = 1'b0, ready_s = 1'b0;
  logic        busy_s, valid_s, to_s, ov_s;
  logic [3:0]  cyc_s, sec_s, rem_s;

  interval_meter #(.CNT_W(32), .TIMEOUT_SECONDS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clock_frequency(freq_a), .start(start_a), .stop(stop_a),
    .busy(busy_a), .result_valid(valid_a), .result_ready(ready_a),
    .elapsed_cycles(cyc_a), .elapsed_seconds(sec_a), .elapsed_remainder(rem_a),
    .timed_out(to_a), .overflow(ov_a));

  interval_meter #(.CNT_W(32), .TIMEOUT_SECONDS(1)) dut_t (
    .clk(clk), .rst_n(rst_n), .clock_frequency(freq_t), .start(start_t), .stop(stop_t),
    .busy(busy_t), .result_valid(valid_t), .result_ready(ready_t),
    .elapsed_cycles(cyc_t), .elapsed_seconds(sec_t), .elapsed_remainder(rem_t),
    .timed_out(to_t), .overflow(ov_t));

  interval_meter #(.CNT_W(4), .TIMEOUT_SECONDS(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .clock_frequency(freq_s), .start(start_s), .stop(stop_s),
    .busy(busy_s), .result_valid(valid_s), .result_ready(ready_s),
    .elapsed_cycles(cyc_s), .elapsed_seconds(sec_s), .elapsed_remainder(rem_s),
    .timed_out(to_s), .overflow(ov_s));

  // Reference model: n cycles at frequency f (0 treated as 1).
  task automatic push_expected(input logic [31:0] f, input int n);
    exp_t e;
    logic [31:0] fe;
    fe = (f == 0) ? 32'd1 : f;
    e.cyc = n;
    e.sec = n / fe;
    e.rem = n % fe;
    e.to  = 1'b0;
    e.ov  = 1'b0;
    exp_q.push_back(e);
  endtask

  // Scoreboard: each new result on the main instance is popped and compared.
  logic valid_a_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (valid_a && !valid_a_d) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: result cycles=%0d with empty expected queue", cyc_a);
      end else begin
        e = exp_q.pop_front();
        checks++; if (cyc_a !== e.cyc) begin errors++; $display("FAIL sb_cycles: got %0d exp %0d", cyc_a, e.cyc); end
        checks++; if (sec_a !== e.sec) begin errors++; $display("FAIL sb_seconds: got %0d exp %0d", sec_a, e.sec); end
        checks++; if (rem_a !== e.rem) begin errors++; $display("FAIL sb_remainder: got %0d exp %0d", rem_a, e.rem); end
        checks++; if (to_a !== e.to) begin errors++; $display("FAIL sb_timed_out: got %0b exp %0b", to_a, e.to); end
        checks++; if (ov_a !== e.ov) begin errors++; $display("FAIL sb_overflow: got %0b exp %0b", ov_a, e.ov); end
      end
    end
    valid_a_d = valid_a;
  end

  // One measurement of n cycles on the main instance; optional start poke mid-run,
  // optional skip of the handshake so the caller can hold the result.
  task automatic measure_a(input logic [31:0] f, input int n, input bit poke, input bit hold);
    @(negedge clk); freq_a = f; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL run_busy: got %0b exp 1", busy_a); end
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      start_a = (poke && i == n / 2);
    end
    start_a = 1'b0; stop_a = 1'b1;
    push_expected(f, n);
    @(negedge clk); stop_a = 1'b0;
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL valid_latency: got %0b exp 1 (n=%0d)", valid_a, n); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL busy_after_stop: got %0b exp 0", busy_a); end
    if (!hold) begin
      ready_a = 1'b1;
      @(negedge clk); ready_a = 1'b0;
      checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL handshake_clear: got %0b exp 0", valid_a); end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if ({busy_a, valid_a, to_a, ov_a} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {busy_a, valid_a, to_a, ov_a}); end
    checks++; if ({cyc_a, sec_a, rem_a} !== 96'b0) begin errors++; $display("FAIL reset_data: got %0d/%0d/%0d exp 0/0/0", cyc_a, sec_a, rem_a); end
    checks++; if ({busy_t, valid_t, busy_s, valid_s} !== 4'b0) begin errors++; $display("FAIL reset_other: got %b exp 0000", {busy_t, valid_t, busy_s, valid_s}); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    measure_a(32'd255, 600, 1'b0, 1'b0);
    measure_a(32'd0, 7, 1'b0, 1'b0);
    measure_a(32'd3, 1, 1'b0, 1'b0);
    measure_a(32'd40, 40, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      measure_a(32'($urandom_range(1, 60)), int'($urandom_range(1, 200)), 1'b1, 1'b0);
  endtask

  task automatic test_idle_pulses;
    @(negedge clk); stop_a = 1'b1;
    @(negedge clk); stop_a = 1'b0;
    checks++; if ({busy_a, valid_a} !== 2'b00) begin errors++; $display("FAIL stop_in_idle: got %b exp 00", {busy_a, valid_a}); end
    freq_a = 32'd2; start_a = 1'b1; stop_a = 1'b1;
    @(negedge clk); start_a = 1'b0; stop_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL start_wins: got %0b exp 1", busy_a); end
    repeat (4) @(negedge clk);
    stop_a = 1'b1;
    push_expected(32'd2, 5);
    @(negedge clk); stop_a = 1'b0;
    ready_a = 1'b1;
    @(negedge clk); ready_a = 1'b0;
  endtask

  task automatic test_back_to_back;
    measure_a(32'd100, 37, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start_a = (i % 2 == 0); stop_a = (i % 2 == 1);
      @(negedge clk);
      checks++; if (valid_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL hold_valid: got v=%0b b=%0b exp v=1 b=0", valid_a, busy_a); end
      checks++; if (cyc_a !== 32'd37 || rem_a !== 32'd37) begin errors++; $display("FAIL hold_data: got %0d/%0d exp 37/37", cyc_a, rem_a); end
    end
    stop_a = 1'b0; start_a = 1'b1; ready_a = 1'b1;
    @(negedge clk); start_a = 1'b0; ready_a = 1'b0;
    checks++; if ({busy_a, valid_a} !== 2'b00) begin errors++; $display("FAIL start_on_handshake: got %b exp 00", {busy_a, valid_a}); end
    measure_a(32'd5, 12, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk); freq_a = 32'd10; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy_a, valid_a} !== 2'b00) begin errors++; $display("FAIL async_reset_flags: got %b exp 00", {busy_a, valid_a}); end
    checks++; if ({cyc_a, sec_a, rem_a} !== 96'b0) begin errors++; $display("FAIL async_reset_data: got %0d/%0d/%0d exp 0/0/0", cyc_a, sec_a, rem_a); end
    @(negedge clk); rst_n = 1'b1;
    measure_a(32'd20, 3, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk); freq_t = 32'd10; start_t = 1'b1;
      @(negedge clk); start_t = 1'b0;
      repeat (9) @(negedge clk);
      checks++; if (valid_t !== 1'b0) begin errors++; $display("FAIL timeout_early: got %0b exp 0", valid_t); end
      stop_t = (s == 1);
      @(negedge clk); stop_t = 1'b0;
      checks++; if (valid_t !== 1'b1) begin errors++; $display("FAIL timeout_valid: got %0b exp 1", valid_t); end
      checks++; if (cyc_t !== 32'd10 || sec_t !== 32'd1 || rem_t !== 32'd0) begin errors++; $display("FAIL timeout_data: got %0d/%0d/%0d exp 10/1/0", cyc_t, sec_t, rem_t); end
      checks++; if (to_t !== (s == 0)) begin errors++; $display("FAIL timeout_flag: got %0b exp %0b", to_t, (s == 0)); end
      ready_t = 1'b1;
      @(negedge clk); ready_t = 1'b0;
    end
  endtask

  task automatic test_saturation;
    @(negedge clk); freq_s = 4'd1; start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    repeat (19) @(negedge clk);
    stop_s = 1'b1;
    @(negedge clk); stop_s = 1'b0;
    checks++; if (valid_s !== 1'b1) begin errors++; $display("FAIL sat_valid: got %0b exp 1", valid_s); end
    checks++; if (cyc_s !== 4'd15 || sec_s !== 4'd15 || rem_s !== 4'd0) begin errors++; $display("FAIL sat_data: got %0d/%0d/%0d exp 15/15/0", cyc_s, sec_s, rem_s); end
    checks++; if (ov_s !== 1'b1 || to_s !== 1'b0) begin errors++; $display("FAIL sat_flags: got ov=%0b to=%0b exp ov=1 to=0", ov_s, to_s); end
    ready_s = 1'b1;
    @(negedge clk); ready_s = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_idle_pulses();
    test_back_to_back();
    test_reset_mid_run();
    test_timeout();
    test_saturation();
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending exp 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
